// File: rtl/wb_mem_responder.sv
// Wishbone B4 classic-cycle slave backed by a line-wide on-chip RAM, with programmable
// wait states, err outside the address window and rty during periodic refresh windows.
module wb_mem_responder #(
  parameter int unsigned CACHE_WIDTH      = 128,
  parameter int unsigned BUS_GRANULARITY  = 32,
  parameter int unsigned MEM_DEPTH        = 10,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter int unsigned WAIT_STATES      = 0,
  parameter int unsigned REFRESH_INTERVAL = 0,
  parameter int unsigned REFRESH_LEN      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            wb_adr_i,
  input  logic [CACHE_WIDTH-1:0]                 wb_dat_i,
  output logic [CACHE_WIDTH-1:0]                 wb_dat_o,
  input  logic                                   wb_we_i,
  input  logic [CACHE_WIDTH/BUS_GRANULARITY-1:0] wb_sel_i,
  input  logic                                   wb_stb_i,
  input  logic                                   wb_cyc_i,
  output logic                                   wb_ack_o,
  output logic                                   wb_err_o,
  output logic                                   wb_rty_o
);

  localparam int unsigned SEL_WIDTH = CACHE_WIDTH / BUS_GRANULARITY;
  localparam int unsigned SelBits   = $clog2(SEL_WIDTH);
  localparam int unsigned NumLines  = 2 ** MEM_DEPTH;
  localparam logic [3:0]  WaitLast  = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q;
  logic [MEM_DEPTH-1:0]   idx_q;
  logic                   we_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [CACHE_WIDTH-1:0] dat_q;
  logic [3:0]             wait_cnt_q;

  logic [CACHE_WIDTH-1:0] mem [NumLines];

  logic                 req;
  logic                 busy;
  logic                 in_window;
  logic                 do_write;
  logic [31:0]          offset;
  logic [MEM_DEPTH-1:0] idx_in;

  assign req       = wb_cyc_i & wb_stb_i;
  assign offset    = wb_adr_i - BASE_ADDR;
  assign idx_in    = offset[SelBits +: MEM_DEPTH];
  assign in_window = (wb_adr_i >= BASE_ADDR) && ((offset >> (MEM_DEPTH + SelBits)) == 32'd0);

  generate
    if (REFRESH_INTERVAL > 0) begin : g_refresh
      logic [31:0] refresh_cnt_q;

      always_ff @(posedge clk) begin
        if (rst || refresh_cnt_q == 32'(REFRESH_INTERVAL - 1)) begin
          refresh_cnt_q <= '0;
        end else begin
          refresh_cnt_q <= refresh_cnt_q + 32'd1;
        end
      end

      assign busy = refresh_cnt_q < 32'(REFRESH_LEN);
    end else begin : g_no_refresh
      assign busy = 1'b0;
    end
  endgenerate

  // The RAM is read on the edge that enters the ack cycle, so read data is ready in RESP
  // even with zero wait states (address taken straight from the bus in that case).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_rty_o   <= 1'b0;
      wb_dat_o   <= '0;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q      <= idx_in;
            we_q       <= wb_we_i;
            sel_q      <= wb_sel_i;
            dat_q      <= wb_dat_i;
            wait_cnt_q <= '0;
            if (busy) begin
              state_q  <= StResp;
              wb_rty_o <= 1'b1;
            end else if (!in_window) begin
              state_q  <= StResp;
              wb_err_o <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q <= StWait;
            end else begin
              state_q  <= StResp;
              wb_ack_o <= 1'b1;
              if (!wb_we_i) wb_dat_o <= mem[idx_in];
            end
          end
        end
        StWait: begin
          if (!req) begin
            state_q <= StIdle;
          end else if (wait_cnt_q == WaitLast) begin
            state_q  <= StResp;
            wb_ack_o <= 1'b1;
            if (!we_q) wb_dat_o <= mem[idx_q];
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Commit only if the master still holds the cycle through the ack.
  assign do_write = (state_q == StResp) && wb_ack_o && we_q && req && !rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
        if (sel_q[i]) begin
          mem[idx_q][i*BUS_GRANULARITY +: BUS_GRANULARITY] <=
              dat_q[i*BUS_GRANULARITY +: BUS_GRANULARITY];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (defaults, 3 wait states, refresh 16/4),
// each driven on its own cyc line and checked against a line-array reference model.
module tb_wb_mem_responder;

  localparam logic [2:0] ACK = 3'b100;
  localparam logic [2:0] ERR = 3'b010;
  localparam logic [2:0] RTY = 3'b001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  adr = '0;
  logic [127:0] dat_in = '0;
  logic         we = 1'b0;
  logic [3:0]   sel = '0;
  logic         stb = 1'b0;
  logic         cyc_d = 1'b0, cyc_w = 1'b0, cyc_r = 1'b0;
  logic         ack_d, err_d, rty_d, ack_w, err_w, rty_w, ack_r, err_r, rty_r;
  logic [127:0] dato_d, dato_w, dato_r;

  int checks = 0;
  int failures = 0;
  int tick;
  logic [127:0] model [int];

  always #5 clk = ~clk;

  // Mirrors the refresh counter's definition: 0 in the first cycle after reset, then +1 per edge.
  always @(posedge clk) begin
    if (rst) tick <= 0;
    else tick <= tick + 1;
  end

  wb_mem_responder dut_d (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_in), .wb_dat_o(dato_d),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc_d),
    .wb_ack_o(ack_d), .wb_err_o(err_d), .wb_rty_o(rty_d)
  );

  wb_mem_responder #(.WAIT_STATES(3)) dut_w (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_in), .wb_dat_o(dato_w),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc_w),
    .wb_ack_o(ack_w), .wb_err_o(err_w), .wb_rty_o(rty_w)
  );

  wb_mem_responder #(.REFRESH_INTERVAL(16), .REFRESH_LEN(4)) dut_r (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_in), .wb_dat_o(dato_r),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc_r),
    .wb_ack_o(ack_r), .wb_err_o(err_r), .wb_rty_o(rty_r)
  );

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old_line, input logic [127:0] wr,
                                         input logic [3:0] s);
    logic [127:0] r;
    r = old_line;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*32 +: 32] = wr[i*32 +: 32];
    return r;
  endfunction

  task automatic set_cyc(input int k, input logic v);
    case (k)
      0: cyc_d = v;
      1: cyc_w = v;
      default: cyc_r = v;
    endcase
  endtask

  task automatic get_out(input int k, output logic [2:0] t, output logic [127:0] o);
    case (k)
      0: begin t = {ack_d, err_d, rty_d}; o = dato_d; end
      1: begin t = {ack_w, err_w, rty_w}; o = dato_w; end
      default: begin t = {ack_r, err_r, rty_r}; o = dato_r; end
    endcase
  endtask

  // One transfer held until termination; lat counts cycles after the sampling edge (-1 = none).
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [127:0] d,
                      input logic [3:0] s, input int at_cnt, output int lat,
                      output logic [2:0] term, output logic [127:0] rd);
    logic [2:0] t;
    logic [127:0] o;
    int guard;
    @(negedge clk);
    guard = 0;
    while (at_cnt >= 0 && (tick % 16) != at_cnt && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    adr = a; dat_in = d; we = w; sel = s; stb = 1'b1; set_cyc(k, 1'b1);
    lat = -1; term = '0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      get_out(k, t, o);
      if (t != 3'b000) begin
        lat = c; term = t; rd = o;
        break;
      end
    end
    @(posedge clk); #1;
    stb = 1'b0; set_cyc(k, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if ({ack_d, err_d, rty_d, dato_d} !== '0) begin failures++;
      $display("FAIL reset_d got %b/%h want 000/0", {ack_d, err_d, rty_d}, dato_d); end
    checks++; if ({ack_w, err_w, rty_w, dato_w} !== '0) begin failures++;
      $display("FAIL reset_w got %b/%h want 000/0", {ack_w, err_w, rty_w}, dato_w); end
    checks++; if ({ack_r, err_r, rty_r, dato_r} !== '0) begin failures++;
      $display("FAIL reset_r got %b/%h want 000/0", {ack_r, err_r, rty_r}, dato_r); end
  endtask

  task automatic test_basic();
    int lat; logic [2:0] term; logic [127:0] rd, d1;
    d1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    xfer(0, 1'b1, 32'h10, d1, 4'hF, -1, lat, term, rd);
    model[4] = d1;
    checks++; if (lat !== 1 || term !== ACK || rd !== '0) begin failures++;
      $display("FAIL basic_wr got lat=%0d term=%b dat=%h want 1/100/0", lat, term, rd); end
    xfer(0, 1'b0, 32'h10, '0, 4'h0, -1, lat, term, rd);
    checks++; if (lat !== 1 || term !== ACK || rd !== d1) begin failures++;
      $display("FAIL basic_rd got lat=%0d term=%b dat=%h want 1/100/%h", lat, term, rd, d1); end
    xfer(0, 1'b0, 32'h13, '0, 4'hF, -1, lat, term, rd);
    checks++; if (term !== ACK || rd !== d1) begin failures++;
      $display("FAIL basic_rd13 got term=%b dat=%h want 100/%h", term, rd, d1); end
  endtask

  task automatic test_partial();
    int lat; logic [2:0] term; logic [127:0] rd;
    xfer(0, 1'b1, 32'h10, {4{32'hFFFF_FFFF}}, 4'b0101, -1, lat, term, rd);
    model[4] = merge(model[4], {4{32'hFFFF_FFFF}}, 4'b0101);
    checks++; if (term !== ACK) begin failures++;
      $display("FAIL partial_wr got term=%b want 100", term); end
    xfer(0, 1'b0, 32'h10, '0, 4'h0, -1, lat, term, rd);
    checks++; if (rd !== 128'h4444_4444_FFFF_FFFF_2222_2222_FFFF_FFFF) begin failures++;
      $display("FAIL partial_rd got %h want 4444..ffff", rd); end
  endtask

  task automatic test_window();
    int lat; logic [2:0] term; logic [127:0] rd, d3;
    xfer(0, 1'b0, 32'h1000, '0, 4'hF, -1, lat, term, rd);
    checks++; if (lat !== 1 || term !== ERR || rd !== '0) begin failures++;
      $display("FAIL window_err got lat=%0d term=%b dat=%h want 1/010/0", lat, term, rd); end
    d3 = rand_line();
    xfer(0, 1'b1, 32'h0FFC, d3, 4'hF, -1, lat, term, rd);
    model[1023] = d3;
    xfer(0, 1'b0, 32'h0FFC, '0, 4'hF, -1, lat, term, rd);
    checks++; if (lat !== 1 || term !== ACK || rd !== d3) begin failures++;
      $display("FAIL window_top got lat=%0d term=%b dat=%h want 1/100/%h", lat, term, rd, d3); end
  endtask

  task automatic test_random();
    int lat, line; logic [2:0] term; logic [127:0] rd, d, exp_rd; logic [31:0] a;
    logic w, outside; logic [3:0] s; logic [2:0] exp_term;
    for (int l = 0; l < 8; l++) begin
      d = rand_line();
      xfer(0, 1'b1, 32'(l * 4), d, 4'hF, -1, lat, term, rd);
      model[l] = d;
    end
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      outside = ($urandom_range(0, 4) == 0);
      a = outside ? $urandom_range(32'h1000, 32'hFFFF_FFFF) : $urandom_range(0, 31);
      s = 4'($urandom_range(0, 15));
      d = rand_line();
      line = int'(a >> 2);
      exp_term = outside ? ERR : ACK;
      exp_rd = (outside || w) ? '0 : model[line];
      xfer(0, w, a, d, s, -1, lat, term, rd);
      if (!outside && w) model[line] = merge(model[line], d, s);
      checks++; if (lat !== 1 || term !== exp_term || rd !== exp_rd) begin failures++;
        $display("FAIL random_%0d adr=%h we=%b got lat=%0d term=%b dat=%h want 1/%b/%h",
                 n, a, w, lat, term, rd, exp_term, exp_rd); end
    end
  endtask

  task automatic test_wait();
    int lat; logic [2:0] term, t; logic [127:0] rd, o, d1, d2;
    d1 = rand_line(); d2 = ~d1;
    xfer(1, 1'b1, 32'h20, d1, 4'hF, -1, lat, term, rd);
    checks++; if (lat !== 4 || term !== ACK) begin failures++;
      $display("FAIL wait_wr got lat=%0d term=%b want 4/100", lat, term); end
    xfer(1, 1'b0, 32'h20, '0, 4'hF, -1, lat, term, rd);
    checks++; if (lat !== 4 || term !== ACK || rd !== d1) begin failures++;
      $display("FAIL wait_rd got lat=%0d term=%b dat=%h want 4/100/%h", lat, term, rd, d1); end
    // Write abandoned after two wait cycles.
    @(negedge clk);
    adr = 32'h20; dat_in = d2; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc_w = 1'b1;
    term = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      get_out(1, t, o);
      term = term | t;
      if (c == 2) stb = 1'b0;
    end
    cyc_w = 1'b0;
    checks++; if (term !== 3'b000) begin failures++;
      $display("FAIL wait_abort_term got %b want 000", term); end
    xfer(1, 1'b0, 32'h20, '0, 4'hF, -1, lat, term, rd);
    checks++; if (term !== ACK || rd !== d1) begin failures++;
      $display("FAIL wait_abort_rd got term=%b dat=%h want 100/%h", term, rd, d1); end
  endtask

  task automatic test_retry();
    int lat, c, line; logic [2:0] term, exp_term; logic [127:0] rd, d, exp_rd; logic w;
    d = rand_line();
    xfer(2, 1'b1, 32'h40, d, 4'hF, 8, lat, term, rd);
    model[2*8192 + 16] = d;
    checks++; if (lat !== 1 || term !== ACK) begin failures++;
      $display("FAIL retry_init got lat=%0d term=%b want 1/100", lat, term); end
    xfer(2, 1'b0, 32'h40, '0, 4'hF, 2, lat, term, rd);
    checks++; if (lat !== 1 || term !== RTY || rd !== '0) begin failures++;
      $display("FAIL retry_busy got lat=%0d term=%b dat=%h want 1/001/0", lat, term, rd); end
    xfer(2, 1'b0, 32'h40, '0, 4'hF, 5, lat, term, rd);
    checks++; if (lat !== 1 || term !== ACK || rd !== d) begin failures++;
      $display("FAIL retry_again got lat=%0d term=%b dat=%h want 1/100/%h", lat, term, rd, d); end
    for (int l = 17; l < 20; l++) begin
      d = rand_line();
      xfer(2, 1'b1, 32'(l * 4), d, 4'hF, 10, lat, term, rd);
      model[2*8192 + l] = d;
    end
    for (int n = 0; n < 16; n++) begin
      c = $urandom_range(0, 15);
      w = 1'($urandom_range(0, 1));
      line = $urandom_range(16, 19);
      d = rand_line();
      exp_term = (c < 4) ? RTY : ACK;
      exp_rd = (c < 4 || w) ? '0 : model[2*8192 + line];
      xfer(2, w, 32'(line * 4), d, 4'hF, c, lat, term, rd);
      if (c >= 4 && w) model[2*8192 + line] = d;
      checks++; if (lat !== 1 || term !== exp_term || rd !== exp_rd) begin failures++;
        $display("FAIL retry_rand_%0d cnt=%0d got lat=%0d term=%b dat=%h want 1/%b/%h",
                 n, c, lat, term, rd, exp_term, exp_rd); end
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [2:0] term, t; logic [127:0] rd, o, d_old;
    logic [127:0] seen;
    d_old = rand_line();
    xfer(1, 1'b1, 32'h24, d_old, 4'hF, -1, lat, term, rd);
    @(negedge clk);
    adr = 32'h24; dat_in = ~d_old; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc_w = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    term = '0; seen = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      get_out(1, t, o);
      term = term | t; seen = seen | o;
    end
    stb = 1'b0; cyc_w = 1'b0; rst = 1'b0;
    checks++; if (term !== 3'b000 || seen !== '0) begin failures++;
      $display("FAIL rst_mid_outputs got term=%b dat=%h want 000/0", term, seen); end
    xfer(1, 1'b0, 32'h24, '0, 4'hF, -1, lat, term, rd);
    checks++; if (lat !== 4 || term !== ACK || rd !== d_old) begin failures++;
      $display("FAIL rst_mid_rd got lat=%0d term=%b dat=%h want 4/100/%h", lat, term, rd, d_old);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_window();
    test_random();
    test_wait();
    test_retry();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
